hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It is the stall/flush counterpart to the EX-stage bypass network: it handles the hazards that forwarding cannot resolve. It detects load-use dependencies between ID and EX, squashes wrong-path instructions on a taken branch or jump resolved in EX, and freezes the pipeline while the data memory has not acknowledged a MEM-stage access. A timeout counter bounds every memory wait.

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage RISC-V pipeline (load-use, branch squash, memory freeze with timeout).
// Optional build macro HAZARD_CTRL_PERF_EN adds registered stall/flush/timeout event counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_wR,
    input  logic        ex_rf_we,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        mem_err
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic [31:0] tmo_events
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic freeze_s;
    logic tmo_s;
    logic lu_s;
    logic rs1_hit_s;
    logic rs2_hit_s;
    logic flush_s;
    logic ld_stall_s;

    // State and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Hazard condition decode: freeze, timeout, load-use
    always_comb begin
        tmo_s = (state_q == ST_MEMWAIT) & ~mem_ready & (wait_cnt_q == LAST_CNT);
        case (state_q)
            ST_RUN:     freeze_s = mem_req & ~mem_ready;
            ST_MEMWAIT: freeze_s = ~mem_ready & ~tmo_s;
            default:    freeze_s = 1'b0;
        endcase
        rs1_hit_s  = id_rs1_used & (id_rs1 == ex_wR);
        rs2_hit_s  = id_rs2_used & (id_rs2 == ex_wR);
        lu_s       = ex_is_load & ex_rf_we & (ex_wR != 5'd0) & (rs1_hit_s | rs2_hit_s);
        // A taken branch squashes the dependent ID instruction, so it outranks load-use
        flush_s    = ex_branch_taken & ~freeze_s;
        ld_stall_s = lu_s & ~freeze_s & ~tmo_s & ~ex_branch_taken;
    end

    // Next-state and wait-counter update
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req & ~mem_ready) begin
                    state_d = ST_MEMWAIT;
                end else begin
                    state_d = ST_RUN;
                end
                wait_cnt_d = CNT_ZERO;
            end
            ST_MEMWAIT: begin
                if (mem_ready | tmo_s) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = CNT_ZERO;
                end else begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Output decode; reset forces every control to its inactive value
    always_comb begin
        pc_stall     = ~rst & (freeze_s | ld_stall_s);
        if_id_stall  = ~rst & (freeze_s | ld_stall_s);
        id_ex_stall  = ~rst & freeze_s;
        ex_mem_stall = ~rst & freeze_s;
        if_id_flush  = ~rst & flush_s;
        id_ex_flush  = ~rst & (flush_s | ld_stall_s);
        mem_wb_flush = ~rst & (freeze_s | tmo_s);
        mem_err      = ~rst & tmo_s;
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;
    logic [31:0] tmo_events_q, tmo_events_d;

    // Event counter next values, wrapping modulo 2^32
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, pc_stall};
        flush_events_d = flush_events_q + {31'd0, if_id_flush};
        tmo_events_d   = tmo_events_q + {31'd0, mem_err};
    end

    // Event counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
            tmo_events_q   <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            tmo_events_q   <= tmo_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
    assign tmo_events   = tmo_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: rule-level reference model checked every cycle, plus hand-computed literals.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = 5'd0;
    logic [4:0] id_rs2 = 5'd0;
    logic       id_rs1_used = 1'b0;
    logic       id_rs2_used = 1'b0;
    logic [4:0] ex_wR = 5'd0;
    logic       ex_rf_we = 1'b0;
    logic       ex_is_load = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;

    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events, tmo_events;
`endif

    hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .mem_err(mem_err)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events), .tmo_events(tmo_events)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b1;

    // Reference model: is an access outstanding, and how many cycles has it already been frozen
    bit m_busy = 1'b0;
    int m_frozen = 0;
    logic [31:0] m_stall = 32'd0, m_flush = 32'd0, m_tmo = 32'd0;

    // Output bits: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush, mem_err}
    function automatic logic [7:0] model_expect();
        bit fz, to, lu;
        logic [7:0] e;
        if (rst) return 8'h00;
        fz = 1'b0;
        to = 1'b0;
        if ((m_busy || mem_req) && !mem_ready) begin
            if (m_frozen < MT) fz = 1'b1;
            else               to = 1'b1;
        end
        lu = ex_is_load && ex_rf_we && (ex_wR != 5'd0) &&
             ((id_rs1_used && id_rs1 == ex_wR) || (id_rs2_used && id_rs2 == ex_wR));
        if (fz) return 8'hF2;
        e = 8'h00;
        if (to) e = e | 8'h03;
        if (ex_branch_taken) e = e | 8'h0C;
        else if (lu && !to) e = e | 8'hC4;
        return e;
    endfunction

    function automatic logic [7:0] dut_out();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_flush, mem_err};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [7:0] e;
        if (rst) begin
            m_busy = 1'b0; m_frozen = 0;
            m_stall = 32'd0; m_flush = 32'd0; m_tmo = 32'd0;
        end else begin
            e = model_expect();
            m_stall = m_stall + {31'd0, e[7]};
            m_flush = m_flush + {31'd0, e[3]};
            m_tmo   = m_tmo + {31'd0, e[0]};
            if (e[5]) begin m_busy = 1'b1; m_frozen = m_frozen + 1; end
            else      begin m_busy = 1'b0; m_frozen = 0; end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e, a;
        if (run_cmp) begin
            e = model_expect();
            a = dut_out();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t actual=%h expected=%h", $time, a, e);
            end
`ifdef HAZARD_CTRL_PERF_EN
            checks++;
            if (stall_cycles !== m_stall || flush_events !== m_flush || tmo_events !== m_tmo) begin
                failures++;
                $display("FAIL perf_cmp t=%0t actual=%0d/%0d/%0d expected=%0d/%0d/%0d", $time,
                         stall_cycles, flush_events, tmo_events, m_stall, m_flush, m_tmo);
            end
`endif
        end
    end

    task automatic set_ex(input logic ld, input logic we, input logic [4:0] wr, input logic br);
        ex_is_load = ld; ex_rf_we = we; ex_wR = wr; ex_branch_taken = br;
    endtask

    task automatic set_id(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    endtask

    task automatic set_mem(input logic rq, input logic rd);
        mem_req = rq; mem_ready = rd;
    endtask

    // One clock cycle: inputs already applied; check a literal mid-cycle, then move past the next rising edge
    task automatic cyc(input string name, input logic [7:0] exp);
        logic [7:0] a;
        @(negedge clk);
        #1;
        a = dut_out();
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, a, exp);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       ld, we;
        logic [4:0] wr;
        logic [4:0] r1; logic u1;
        logic [4:0] r2; logic u2;
        logic [7:0] exp;
    } lu_vec_t;

    lu_vec_t lu_tab[5] = '{
        '{1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 8'hC4},
        '{1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 8'h00},
        '{1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 8'h00},
        '{1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 8'h00},
        '{1'b1, 1'b1, 5'd8, 5'd7, 1'b1, 5'd9, 1'b1, 8'h00}
    };

    initial begin
        cyc("reset", 8'h00);
        rst = 1'b0;
        cyc("idle", 8'h00);

        set_ex(1'b1, 1'b1, 5'd5, 1'b0); set_id(5'd0, 1'b0, 5'd5, 1'b1);
        cyc("lu_stall", 8'hC4);
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        cyc("lu_bubble", 8'h00);
        set_ex(1'b1, 1'b1, 5'd0, 1'b0); set_id(5'd0, 1'b0, 5'd0, 1'b1);
        cyc("lu_x0", 8'h00);

        foreach (lu_tab[i]) begin
            set_ex(lu_tab[i].ld, lu_tab[i].we, lu_tab[i].wr, 1'b0);
            set_id(lu_tab[i].r1, lu_tab[i].u1, lu_tab[i].r2, lu_tab[i].u2);
            cyc($sformatf("lu_tab%0d", i), lu_tab[i].exp);
        end

        set_ex(1'b1, 1'b1, 5'd5, 1'b1); set_id(5'd0, 1'b0, 5'd5, 1'b1);
        cyc("branch_over_lu", 8'h0C);
        set_ex(1'b0, 1'b0, 5'd0, 1'b1); set_id(5'd0, 1'b0, 5'd0, 1'b0);
        cyc("branch_only", 8'h0C);
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);

        // Three-cycle memory wait then acknowledge
        set_mem(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("mem_wait", 8'hF2);
        set_mem(1'b1, 1'b1);
        cyc("mem_ack", 8'h00);
        set_mem(1'b0, 1'b0);
        cyc("after_ack_run", 8'h00);

        set_mem(1'b1, 1'b1);
        cyc("zero_cost_ack", 8'h00);
        set_mem(1'b0, 1'b0);
        cyc("zero_cost_after", 8'h00);

        // Timeout: MT frozen cycles, then one mem_err cycle
        set_mem(1'b1, 1'b0);
        for (int i = 0; i < MT; i++) cyc("tmo_frozen", 8'hF2);
        cyc("tmo_pulse", 8'h03);
        set_mem(1'b0, 1'b0);
        cyc("after_tmo", 8'h00);
`ifdef HAZARD_CTRL_PERF_EN
        checks++;
        if (tmo_events !== 32'd1) begin
            failures++;
            $display("FAIL tmo_events actual=%0d expected=1", tmo_events);
        end
`endif

        // Acknowledge on the last allowed cycle, then a back-to-back access
        set_mem(1'b1, 1'b0);
        for (int i = 0; i < MT; i++) cyc("limit_frozen", 8'hF2);
        set_mem(1'b1, 1'b1);
        cyc("ack_at_limit", 8'h00);
        set_mem(1'b1, 1'b0);
        for (int i = 0; i < MT; i++) cyc("b2b_frozen", 8'hF2);
        set_mem(1'b1, 1'b1);
        cyc("b2b_ack", 8'h00);
        set_mem(1'b0, 1'b0);
        cyc("b2b_idle", 8'h00);

        // Branch held during a freeze flushes in the ack cycle
        set_mem(1'b1, 1'b0); set_ex(1'b0, 1'b0, 5'd0, 1'b1);
        cyc("br_frozen1", 8'hF2);
        cyc("br_frozen2", 8'hF2);
        set_mem(1'b1, 1'b1);
        cyc("br_after_freeze", 8'h0C);
        set_mem(1'b0, 1'b0); set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        cyc("br_idle", 8'h00);

        // Reset on the second frozen cycle aborts the wait
        set_mem(1'b1, 1'b0);
        cyc("rw_frozen1", 8'hF2);
        rst = 1'b1;
        cyc("rst_mid_wait", 8'h00);
        rst = 1'b0; set_mem(1'b0, 1'b0);
        cyc("rst_release", 8'h00);
        set_mem(1'b1, 1'b0);
        for (int i = 0; i < MT; i++) cyc("post_rst_frozen", 8'hF2);
        cyc("post_rst_tmo", 8'h03);
        set_mem(1'b0, 1'b0);
        cyc("final_idle", 8'h00);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
